// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared VGA timing constants (640x480 @ 60 Hz, 25.175 MHz
//                pixel clock) and the vertical-phase state type used by the
//                vertical timing stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // Vertical timing, in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Vertical phase of the frame
    typedef enum logic [1:0] {
        V_PH_ACTIVE = 2'd0,
        V_PH_FRONT  = 2'd1,
        V_PH_SYNC   = 2'd2,
        V_PH_BACK   = 2'd3
    } v_phase_e;

    // Phase that follows the given one; BACK closes the frame and returns
    // to ACTIVE.
    function automatic v_phase_e v_phase_next(input v_phase_e ph);
        v_phase_e nxt;
        case (ph)
            V_PH_ACTIVE: nxt = V_PH_FRONT;
            V_PH_FRONT:  nxt = V_PH_SYNC;
            V_PH_SYNC:   nxt = V_PH_BACK;
            default:     nxt = V_PH_ACTIVE;
        endcase
        return nxt;
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/v_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : v_counter_if
//  Description : Signal bundle between the horizontal counter / consumers
//                and the vertical timing stage.
//                  trig_v      - end-of-line strobe (into v_counter)
//                  v_count     - current line index, 10 bit
//                  vsync       - vertical sync
//                  v_video_on  - vertical video enable
//                  frame_start - one-cycle start-of-frame pulse
//                  frame_cnt   - 16-bit frame counter, present only when
//                                V_COUNTER_FRAME_CNT_EN is defined
//                Modports: master (line source / consumers), slave (v_counter)
//  Revision    : 1.0 - initial release
// ============================================================================
interface v_counter_if;

    logic       trig_v;
    logic [9:0] v_count;
    logic       vsync;
    logic       v_video_on;
    logic       frame_start;
`ifdef V_COUNTER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

`ifdef V_COUNTER_FRAME_CNT_EN
    modport master (
        output trig_v,
        input  v_count,
        input  vsync,
        input  v_video_on,
        input  frame_start,
        input  frame_cnt
    );

    modport slave (
        input  trig_v,
        output v_count,
        output vsync,
        output v_video_on,
        output frame_start,
        output frame_cnt
    );
`else
    modport master (
        output trig_v,
        input  v_count,
        input  vsync,
        input  v_video_on,
        input  frame_start
    );

    modport slave (
        input  trig_v,
        output v_count,
        output vsync,
        output v_video_on,
        output frame_start
    );
`endif

endinterface : v_counter_if
`default_nettype wire

// File: rtl/v_counter.sv
`default_nettype none
// ============================================================================
//  Module      : v_counter
//  Description : Vertical timing stage of the VGA pipeline. Counts lines on
//                each end-of-line strobe, tracks the vertical phase
//                (ACTIVE/FRONT/SYNC/BACK) and drives registered vsync,
//                vertical video enable and a start-of-frame pulse.
//  Ports       : clk    - pixel clock
//                rst_n  - asynchronous active-low reset
//                bus    - v_counter_if.slave (trig_v in; v_count, vsync,
//                         v_video_on, frame_start [, frame_cnt] out)
//  Options     : V_COUNTER_FRAME_CNT_EN - adds a 16-bit wrapping frame
//                counter that steps together with frame_start.
//  Notes       : V_ACTIVE+V_FP+V_SYNC+V_BP must not exceed 1024 and no
//                phase may be 0 lines long.
//  Revision    : 1.0 - initial release
// ============================================================================
module v_counter
    import vga_timing_pkg::*;
#(
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter bit VSYNC_POL = 1'b0
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    v_counter_if.slave  bus
);

    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last line index of the frame and last per-phase index of each phase.
    // The wrap is an explicit compare so non power-of-two frames work.
    localparam logic [9:0] C_V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_ACTIVE_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] C_FP_LAST     = 10'(V_FP - 1);
    localparam logic [9:0] C_SYNC_LAST   = 10'(V_SYNC - 1);
    localparam logic [9:0] C_BP_LAST     = 10'(V_BP - 1);

    v_phase_e   r_state;
    v_phase_e   w_state_nxt;
    logic [9:0] r_phase_cnt;
    logic [9:0] w_phase_cnt_nxt;
    logic [9:0] w_phase_last;
    logic [9:0] r_v_count;
    logic [9:0] w_v_count_nxt;
    logic       w_wrap;

    logic       r_vsync;
    logic       r_video_on;
    logic       r_frame_start;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= V_PH_ACTIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, next line and next phase count
    // ------------------------------------------------------------------
    always_comb begin
        w_phase_last = C_BP_LAST;
        case (r_state)
            V_PH_ACTIVE: w_phase_last = C_ACTIVE_LAST;
            V_PH_FRONT:  w_phase_last = C_FP_LAST;
            V_PH_SYNC:   w_phase_last = C_SYNC_LAST;
            default:     w_phase_last = C_BP_LAST;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_cnt_nxt = r_phase_cnt;
        w_v_count_nxt   = r_v_count;
        w_wrap          = 1'b0;

        if (bus.trig_v) begin
            if (r_v_count == C_V_LAST) begin
                w_v_count_nxt = 10'd0;
                w_wrap        = 1'b1;
            end else begin
                w_v_count_nxt = r_v_count + 10'd1;
            end

            // The strobe that ends the last line of a phase moves to the
            // next phase; the BACK->ACTIVE move lines up with the wrap.
            if (r_phase_cnt == w_phase_last) begin
                w_state_nxt     = v_phase_next(r_state);
                w_phase_cnt_nxt = 10'd0;
            end else begin
                w_phase_cnt_nxt = r_phase_cnt + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line and phase counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v_count   <= 10'd0;
            r_phase_cnt <= 10'd0;
        end else begin
            r_v_count   <= w_v_count_nxt;
            r_phase_cnt <= w_phase_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output registers. Decoded from the next state so they change in
    // the same cycle as v_count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_video_on    <= 1'b1;
            r_vsync       <= ~VSYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            // frame_start is a pulse: cleared on any cycle that is not a wrap
            r_frame_start <= w_wrap;
            if (bus.trig_v) begin
                r_video_on <= (w_state_nxt == V_PH_ACTIVE);
                r_vsync    <= (w_state_nxt == V_PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end

    assign bus.v_count     = r_v_count;
    assign bus.vsync       = r_vsync;
    assign bus.v_video_on  = r_video_on;
    assign bus.frame_start = r_frame_start;

`ifdef V_COUNTER_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Steps on the same edge that raises frame_start; wraps 0xFFFF -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'd0;
        end else if (w_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign bus.frame_cnt = r_frame_cnt;
`endif

endmodule : v_counter
`default_nettype wire
